rx_prog_loader: RTL and testbench

- Byte-stream program loader that sits directly upstream of the CPU+memory top level.
- Consumes the 8-bit rx_data byte stream and assembles 32-bit little-endian words.
- Pushes each word through a 2-entry buffer into the memory load port, and holds the CPU in reset until the image is loaded.
- Also drives the rx_check / rx_checkh / rx_checkl debug words consumed by the board display.

---
 rtl/loader_pkg.sv | 16 +
 rtl/loader_fifo.sv | 53 +++++
 rtl/rx_prog_loader.sv | 171 +++++++++++++++++
 tb/tb_rx_prog_loader.sv | 384 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared types and constants for the rx_prog_loader byte-stream program loader.
package loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        DATA,
        CSUM,
        DONE,
        ERR
    } ldr_state_t;

    localparam logic [7:0]  SYNC_BYTE = 8'hA5;
    localparam int unsigned WORD_W    = 32;

endpackage

// File: rtl/loader_fifo.sv
// Small synchronous word FIFO with flush; push is dropped when full unless a pop
// frees a slot in the same cycle.
module loader_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wp;
    logic [AW:0]      rp;
    logic             do_pop;
    logic             do_push;

    assign count   = wp - rp;
    assign full    = (count == (AW + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign dout    = mem[rp[AW-1:0]];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Pointer update; flush discards all entries.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wp <= '0;
            rp <= '0;
        end else if (flush) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (do_push) wp <= wp + 1'b1;
            if (do_pop)  rp <= rp + 1'b1;
        end
    end

    // Storage write.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wp[AW-1:0]] <= din;
    end

endmodule

// File: rtl/rx_prog_loader.sv
// Byte-stream program loader: SYNC, length, little-endian data words, pushed
// through a small FIFO into the memory load port; holds the CPU in reset until
// the image is written. Optional checksum byte enabled by LOADER_CSUM_EN.
module rx_prog_loader
    import loader_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned FIFO_D = 2,
    parameter logic [7:0]  SYNC   = SYNC_BYTE
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic [ADDR_W-1:0] ld_adr,
    output logic [WORD_W-1:0] ld_data,
    output logic              ld_we,
    input  logic              ld_ready,
    output logic              cpu_reset,
    output logic              load_done,
    output logic              err,
    output logic [WORD_W-1:0] rx_check,
    output logic [WORD_W-1:0] rx_checkl,
    output logic [WORD_W-1:0] rx_checkh
);

    localparam int unsigned CNT_W = $clog2(FIFO_D) + 1;

    ldr_state_t        state;
    ldr_state_t        state_n;
    logic              armed;
    logic              rx_ok;
    logic              is_sync;
    logic              restart;
    logic [1:0]        byte_cnt;
    logic [7:0]        word_cnt;
    logic [7:0]        wlen;
    logic [23:0]       shreg;
    logic              word_done;
    logic              last_word;
    logic [WORD_W-1:0] word_asm;
    logic              push_q;
    logic [WORD_W-1:0] push_word;
    logic              pop;
    logic              flush;
    logic              overflow;
    logic              fifo_drain;
    logic [WORD_W-1:0] f_dout;
    logic              f_full;
    logic              f_empty;
    logic [CNT_W-1:0]  f_cnt;
`ifdef LOADER_CSUM_EN
    logic [7:0]        csum;
`endif

    // armed is low for the first edge after reset release, so a byte on that edge is dropped
    assign rx_ok      = rx_valid && armed;
    assign is_sync    = rx_ok && (rx_data == SYNC);
    assign restart    = ((state == IDLE) || (state == ERR)) && is_sync;
    assign word_done  = (state == DATA) && rx_ok && (byte_cnt == 2'd3);
    assign last_word  = word_done && (word_cnt == (wlen - 8'd1));
    assign word_asm   = {rx_data, shreg};
    assign pop        = ld_we && ld_ready;
    assign overflow   = push_q && f_full && !pop;
    // All words written: nothing staged and the FIFO is (or is becoming) empty.
    assign fifo_drain = !push_q && (f_empty || (pop && (f_cnt == CNT_W'(1))));
    assign flush      = (state_n == ERR);

    assign ld_we      = !f_empty;
    assign ld_data    = f_empty ? '0 : f_dout;
    assign err        = (state == ERR);
    assign cpu_reset  = !load_done;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_n;
    end

    // Next-state logic; a FIFO overflow overrides any frame progress.
    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (is_sync) state_n = LEN;
            LEN:  if (rx_ok) state_n = (rx_data == 8'd0) ? ERR : DATA;
`ifdef LOADER_CSUM_EN
            DATA: if (last_word) state_n = CSUM;
            CSUM: if (rx_ok) state_n = (rx_data == csum) ? DONE : ERR;
`else
            DATA: if (last_word) state_n = DONE;
            CSUM: state_n = ERR;
`endif
            DONE: state_n = DONE;
            ERR:  if (is_sync) state_n = LEN;
            default: state_n = IDLE;
        endcase
        if (overflow && (state != IDLE) && (state != ERR)) state_n = ERR;
    end

    // Byte assembly, counters, load address, debug words and completion flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            armed     <= 1'b0;
            byte_cnt  <= '0;
            word_cnt  <= '0;
            wlen      <= '0;
            shreg     <= '0;
            push_q    <= 1'b0;
            push_word <= '0;
            ld_adr    <= '0;
            rx_check  <= '0;
            rx_checkl <= '0;
            rx_checkh <= '0;
            load_done <= 1'b0;
        end else begin
            armed     <= 1'b1;
            // A word completed on the same edge as an error is not staged.
            push_q    <= word_done && (state_n != ERR);
            push_word <= word_asm;
            if (restart) begin
                byte_cnt <= '0;
                word_cnt <= '0;
                ld_adr   <= '0;
            end else begin
                if (pop) ld_adr <= ld_adr + 1'b1;
                if ((state == LEN) && rx_ok) wlen <= rx_data;
                if ((state == DATA) && rx_ok) begin
                    byte_cnt <= byte_cnt + 2'd1;
                    shreg    <= {rx_data, shreg[23:8]};
                    if (byte_cnt == 2'd3) begin
                        word_cnt <= word_cnt + 8'd1;
                        rx_check <= word_asm;
                        if (word_cnt[0]) rx_checkh <= word_asm;
                        else             rx_checkl <= word_asm;
                    end
                end
            end
            if ((state == DONE) && fifo_drain) load_done <= 1'b1;
        end
    end

`ifdef LOADER_CSUM_EN
    // Running XOR of data bytes, cleared on every accepted SYNC.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            csum <= '0;
        end else if (restart) begin
            csum <= '0;
        end else if ((state == DATA) && rx_ok) begin
            csum <= csum ^ rx_data;
        end
    end
`endif

    loader_fifo #(
        .DEPTH (FIFO_D),
        .WIDTH (WORD_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_q),
        .pop   (pop),
        .flush (flush),
        .din   (push_word),
        .dout  (f_dout),
        .full  (f_full),
        .empty (f_empty),
        .count (f_cnt)
    );

endmodule

// File: tb/tb_rx_prog_loader.sv
// Self-checking bench for rx_prog_loader: directed frames plus randomized frames
// checked against a frame-level reference model.
module tb_rx_prog_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  ld_adr;
    logic [31:0] ld_data;
    logic        ld_we;
    logic        ld_ready;
    logic        cpu_reset;
    logic        load_done;
    logic        err;
    logic [31:0] rx_check;
    logic [31:0] rx_checkl;
    logic [31:0] rx_checkh;

    rx_prog_loader #(
        .ADDR_W (8),
        .FIFO_D (2),
        .SYNC   (8'hA5)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .ld_adr    (ld_adr),
        .ld_data   (ld_data),
        .ld_we     (ld_we),
        .ld_ready  (ld_ready),
        .cpu_reset (cpu_reset),
        .load_done (load_done),
        .err       (err),
        .rx_check  (rx_check),
        .rx_checkl (rx_checkl),
        .rx_checkh (rx_checkh)
    );

    always #5 clk = ~clk;

    int unsigned total = 0;
    int unsigned bad   = 0;
    int unsigned cyc   = 0;

    logic [7:0]  frame[$];
    int unsigned byte_cyc[$];
    logic [39:0] expq[$];
    logic [31:0] exp_chk, exp_l, exp_h;
    int unsigned gap_max = 0;
    int unsigned rmode = 0;
    bit          mon_en = 1;
    bit          seen_we, seen_wr, bp_started;
    int unsigned bp_left, zrun;
    int unsigned first_we_cyc, first_wr_cyc, last_wr_cyc, done_cyc;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // ld_ready driver: 0 = always ready, 1 = random (never more than 2 idle in a row),
    // 2 = never ready, 3 = six-cycle stall starting at the first ld_we.
    initial begin
        ld_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (rmode)
                0: ld_ready = 1'b1;
                1: begin
                    ld_ready = (zrun >= 2) ? 1'b1 : ($urandom_range(0, 2) != 0);
                    zrun = ld_ready ? 0 : zrun + 1;
                end
                2: ld_ready = 1'b0;
                default: begin
                    if (!bp_started) begin
                        ld_ready = 1'b0;
                        if (ld_we) begin bp_started = 1; bp_left = 5; end
                    end else if (bp_left > 0) begin
                        ld_ready = 1'b0;
                        bp_left--;
                    end else begin
                        ld_ready = 1'b1;
                    end
                end
            endcase
        end
    end

    // Write-port monitor: order/values against the expected queue, hold-while-stalled.
    initial begin
        bit          hold_v = 0;
        logic [7:0]  hadr;
        logic [31:0] hdata;
        logic [39:0] e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                hold_v = 0;
            end else begin
                if (hold_v && mon_en) begin
                    chk("hold_we", ld_we, 1);
                    chk("hold_adr", ld_adr, hadr);
                    chk("hold_data", ld_data, hdata);
                end
                hold_v = ld_we && !ld_ready;
                hadr   = ld_adr;
                hdata  = ld_data;
                if (ld_we && !seen_we) begin seen_we = 1; first_we_cyc = cyc; end
                if (ld_we && ld_ready && mon_en) begin
                    if (!seen_wr) begin seen_wr = 1; first_wr_cyc = cyc; end
                    if (expq.size() == 0) begin
                        chk("extra_write", {ld_adr, ld_data}, 0);
                    end else begin
                        e = expq.pop_front();
                        chk("wr_adr", ld_adr, e[39:32]);
                        chk("wr_data", ld_data, e[31:0]);
                    end
                    last_wr_cyc = cyc;
                end
            end
        end
    end

    task automatic idle(input int unsigned n);
        repeat (n) begin @(posedge clk); #1; rx_valid = 1'b0; end
    endtask

    task automatic send_byte(input logic [7:0] b, input int unsigned gap);
        repeat (gap) begin @(posedge clk); #1; rx_valid = 1'b0; end
        @(posedge clk); #1;
        rx_valid = 1'b1;
        rx_data  = b;
        byte_cyc.push_back(cyc);
    endtask

    task automatic send_frame();
        byte_cyc.delete();
        foreach (frame[i]) send_byte(frame[i], (gap_max == 0) ? 0 : $urandom_range(0, gap_max));
        idle(1);
    endtask

    // Appends the XOR of all data bytes (everything after SYNC and length) when enabled.
    task automatic add_csum();
`ifdef LOADER_CSUM_EN
        logic [7:0] x = 8'h00;
        int unsigned k = 0;
        while (frame[k] != 8'hA5) k++;
        for (int unsigned i = k + 2; i < frame.size(); i++) x ^= frame[i];
        frame.push_back(x);
`endif
    endtask

    // Frame-level reference: parses the byte list and queues the expected writes.
    task automatic model_frame(output bit fbad);
        int unsigned k = 0;
        int unsigned n;
        logic [31:0] w;
        logic [7:0]  x = 8'h00;
        while (k < frame.size() && frame[k] != 8'hA5) k++;
        n    = frame[k + 1];
        fbad = (n == 0);
        for (int unsigned i = 0; i < n; i++) begin
            w = {frame[k+5+4*i], frame[k+4+4*i], frame[k+3+4*i], frame[k+2+4*i]};
            x ^= w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
            expq.push_back({8'(i % 256), w});
            if (i % 2 == 0) exp_l = w; else exp_h = w;
            exp_chk = w;
        end
`ifdef LOADER_CSUM_EN
        if (n != 0 && frame[k + 2 + 4*n] != x) fbad = 1;
`else
        if (x == 8'h00) x = 8'h00;
`endif
    endtask

    task automatic wait_done(input string tag, input int unsigned budget);
        for (int unsigned i = 0; i < budget; i++) begin
            @(negedge clk);
            if (load_done) break;
        end
        chk(tag, load_done, 1);
        done_cyc = cyc;
    endtask

    task automatic do_reset(input bit check);
        reset = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        if (check) begin
            chk("rst_adr", ld_adr, 0);
            chk("rst_data", ld_data, 0);
            chk("rst_we", ld_we, 0);
            chk("rst_cpu_reset", cpu_reset, 1);
            chk("rst_done", load_done, 0);
            chk("rst_err", err, 0);
            chk("rst_check", rx_check, 0);
            chk("rst_checkl", rx_checkl, 0);
            chk("rst_checkh", rx_checkh, 0);
        end
        expq.delete();
        seen_we = 0; seen_wr = 0; bp_started = 0; zrun = 0;
        exp_chk = '0; exp_l = '0; exp_h = '0;
        reset = 1'b1;
        idle(2);
    endtask

    function automatic void set_two_word();
        frame = '{8'hA5, 8'h02, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    endfunction

    initial begin
        bit fbad;
        int unsigned w;
        reset = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        do_reset(1);

        // A SYNC presented on the reset-release edge must be ignored.
        reset = 1'b0;
        @(negedge clk);
        rx_valid = 1'b1; rx_data = 8'hA5;
        #3 reset = 1'b1;
        @(posedge clk); #1 rx_data = 8'h00;
        idle(3);
        chk("release_edge_err", err, 0);
        do_reset(0);

        // Two-word load with ld_ready high.
        rmode = 0; gap_max = 0;
        set_two_word(); add_csum();
        model_frame(fbad);
        send_frame();
        wait_done("t1_done", 200);
        chk("t1_we_latency", first_we_cyc - byte_cyc[5], 2);
        chk("t1_done_latency", done_cyc - last_wr_cyc, 1);
        chk("t1_cpu_reset", cpu_reset, 0);
        chk("t1_checkl", rx_checkl, 32'h12345678);
        chk("t1_checkh", rx_checkh, 32'hDEADBEEF);
        chk("t1_check", rx_check, 32'hDEADBEEF);
        chk("t1_left", expq.size(), 0);
        chk("t1_err", err, 0);
        // Bytes after completion are ignored.
        frame = '{8'hA5, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04};
        send_frame(); idle(5);
        chk("t1_sticky_done", load_done, 1);
        chk("t1_sticky_we", ld_we, 0);
        chk("t1_sticky_check", rx_check, 32'hDEADBEEF);

        // Backpressure: six stalled cycles from the first ld_we.
        do_reset(0);
        rmode = 3;
        set_two_word(); add_csum();
        model_frame(fbad);
        send_frame();
        wait_done("t2_done", 200);
        chk("t2_stall_len", first_wr_cyc - first_we_cyc, 6);
        chk("t2_left", expq.size(), 0);
        chk("t2_err", err, 0);
        chk("t2_checkl", rx_checkl, 32'h12345678);
        chk("t2_checkh", rx_checkh, 32'hDEADBEEF);

        // Overflow: three words with ld_ready held low.
        do_reset(0);
        rmode = 2; mon_en = 0;
        frame = '{8'hA5, 8'h03};
        for (int i = 0; i < 12; i++) frame.push_back(8'($urandom));
        byte_cyc.delete();
        foreach (frame[i]) begin
            send_byte(frame[i], 0);
            if (i == 12) begin
                chk("t3_pre_err", err, 0);
                chk("t3_pre_we", ld_we, 1);
            end
        end
        idle(4);
        chk("t3_err", err, 1);
        chk("t3_cpu_reset", cpu_reset, 1);
        chk("t3_we_flushed", ld_we, 0);
        chk("t3_done", load_done, 0);
        mon_en = 1; rmode = 0;

        // Zero length then resync.
        do_reset(0);
        frame = '{8'hA5, 8'h00};
        model_frame(fbad);
        send_frame(); idle(3);
        chk("t4_zero_err", err, 1);
        chk("t4_zero_cpu", cpu_reset, 1);
        frame = '{8'hA5, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00}; add_csum();
        model_frame(fbad);
        send_frame();
        wait_done("t4_done", 200);
        chk("t4_err_cleared", err, 0);
        chk("t4_checkl", rx_checkl, 32'h00000001);
        chk("t4_left", expq.size(), 0);

`ifdef LOADER_CSUM_EN
        // Checksum match and mismatch.
        do_reset(0);
        frame = '{8'hA5, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
        model_frame(fbad);
        send_frame();
        wait_done("t5_match_done", 200);
        chk("t5_match_err", err, 0);
        do_reset(0);
        frame = '{8'hA5, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h45};
        model_frame(fbad);
        byte_cyc.delete();
        for (int i = 0; i < 6; i++) send_byte(frame[i], 0);
        send_byte(frame[6], 4);
        idle(3);
        chk("t5_bad_err", err, 1);
        chk("t5_bad_done", load_done, 0);
        chk("t5_bad_cpu", cpu_reset, 1);
        chk("t5_bad_left", expq.size(), 0);
`endif

        // Mid-frame reset after the second data byte.
        do_reset(0);
        byte_cyc.delete();
        send_byte(8'hA5, 0); send_byte(8'h02, 0); send_byte(8'h78, 0); send_byte(8'h56, 0);
        @(posedge clk); #3 reset = 1'b0;
        #1;
        chk("t6_adr", ld_adr, 0);
        chk("t6_data", ld_data, 0);
        chk("t6_we", ld_we, 0);
        chk("t6_cpu", cpu_reset, 1);
        chk("t6_err", err, 0);
        chk("t6_check", rx_check, 0);
        do_reset(0);
        set_two_word(); add_csum();
        model_frame(fbad);
        send_frame();
        wait_done("t6_done", 200);
        chk("t6_left", expq.size(), 0);
        chk("t6_checkh", rx_checkh, 32'hDEADBEEF);

        // Randomized frames with byte gaps and bounded ld_ready stalls.
        rmode = 1; gap_max = 2;
        for (int t = 0; t < 12; t++) begin
            do_reset(0);
            frame.delete();
            repeat ($urandom_range(0, 2)) frame.push_back(8'($urandom_range(0, 8'hA4)));
            frame.push_back(8'hA5);
            w = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 5);
            frame.push_back(8'(w));
            for (int unsigned i = 0; i < 4 * w; i++) frame.push_back(8'($urandom));
            if (w != 0) add_csum();
            model_frame(fbad);
            send_frame();
            if (fbad) begin
                idle(4);
                chk("rnd_err", err, 1);
                chk("rnd_err_we", ld_we, 0);
                chk("rnd_err_done", load_done, 0);
            end else begin
                wait_done("rnd_done", 400);
                chk("rnd_err_clear", err, 0);
                chk("rnd_check", rx_check, exp_chk);
                chk("rnd_checkl", rx_checkl, exp_l);
                chk("rnd_checkh", rx_checkh, exp_h);
                chk("rnd_cpu", cpu_reset, 0);
            end
            chk("rnd_left", expq.size(), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time bound so the run always ends.
    initial begin
        #2000000;
        $display("FAIL timeout got=%0d exp=0", cyc);
        $fatal(1, "timeout");
    end

endmodule
